// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Predicts in IF, trains and produces redirect/perf counters from EX.
module branch_predictor_btb #(
  parameter int ENTRIES  = 64,
  parameter int CNT_BITS = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCF,
  output logic            BtbHitF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            BranchValidE,
  input  logic [XLEN-1:0] PCE,
  input  logic            BranchTakenE,
  input  logic [XLEN-1:0] BranchTargetE,
  input  logic            PredTakenE,
  output logic [1:0]      RedirectE,
  output logic [XLEN-1:0] RedirectPCE,
  input  logic            ClearCnt,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MissCnt
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [CNT_BITS-1:0] CTR_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CTR_WN  = CTR_WT - CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CTR_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CTR_MIN = '0;

  logic                entry_valid  [ENTRIES];
  logic [TAGW-1:0]     entry_tag    [ENTRIES];
  logic [XLEN-1:0]     entry_target [ENTRIES];
  logic [CNT_BITS-1:0] entry_ctr    [ENTRIES];

  logic [IDX-1:0]  idx_f;
  logic [TAGW-1:0] tag_f;
  logic [IDX-1:0]  idx_e;
  logic [TAGW-1:0] tag_e;
  logic            hit_e;
  logic            unused_pc_bits;

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[XLEN-1:IDX+2];
  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[XLEN-1:IDX+2];
  assign unused_pc_bits = ^PCF[1:0];

  // IF lookup reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    BtbHitF     = entry_valid[idx_f] && (entry_tag[idx_f] == tag_f);
    PredTakenF  = BtbHitF && entry_ctr[idx_f][CNT_BITS-1];
    PredTargetF = BtbHitF ? entry_target[idx_f] : '0;
  end

  assign hit_e = entry_valid[idx_e] && (entry_tag[idx_e] == tag_e);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic                valid_q, valid_d;
      logic [TAGW-1:0]     tag_q, tag_d;
      logic [XLEN-1:0]     target_q, target_d;
      logic [CNT_BITS-1:0] ctr_q, ctr_d;
      logic                sel;

      assign sel = BranchValidE && (idx_e == IDX'(gi));

      always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (sel) begin
          if (hit_e) begin
            if (BranchTakenE) begin
              ctr_d    = (ctr_q == CTR_MAX) ? CTR_MAX : ctr_q + CNT_BITS'(1);
              target_d = BranchTargetE;
            end else begin
              ctr_d    = (ctr_q == CTR_MIN) ? CTR_MIN : ctr_q - CNT_BITS'(1);
            end
          end else if (BranchTakenE) begin
            // Allocation replaces whatever aliased here; not-taken misses are ignored.
            valid_d  = 1'b1;
            tag_d    = tag_e;
            target_d = BranchTargetE;
            ctr_d    = CTR_WT;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q  <= 1'b0;
          tag_q    <= '0;
          target_q <= '0;
          ctr_q    <= CTR_WN;
        end else begin
          valid_q  <= valid_d;
          tag_q    <= tag_d;
          target_q <= target_d;
          ctr_q    <= ctr_d;
        end
      end

      assign entry_valid[gi]  = valid_q;
      assign entry_tag[gi]    = tag_q;
      assign entry_target[gi] = target_q;
      assign entry_ctr[gi]    = ctr_q;
    end
  endgenerate

  always_comb begin
    RedirectE   = 2'b00;
    RedirectPCE = '0;
    if (BranchValidE) begin
      if (BranchTakenE && !PredTakenE) begin
        RedirectE   = 2'b01;
        RedirectPCE = BranchTargetE;
      end else if (!BranchTakenE && PredTakenE) begin
        RedirectE   = 2'b11;
        RedirectPCE = PCE + XLEN'(4);
      end
    end
  end

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Clear wins over the event arriving on the same edge.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (ClearCnt) begin
      branch_cnt_d = '0;
      miss_cnt_d   = '0;
    end else begin
      if (BranchValidE)       branch_cnt_d = branch_cnt_q + 32'd1;
      if (RedirectE != 2'b00) miss_cnt_d   = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: a 2-bit/64-entry instance and a 1-bit/16-entry instance
// sharing stimulus; the second is held in reset while the first is exercised.
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_n_a, rst_n_b;
  logic [31:0] pcf, pce, tgt_e;
  logic        valid_e, taken_e, pred_e, clr;

  logic        hit_a, pt_a, hit_b, pt_b;
  logic [31:0] ptgt_a, ptgt_b, rpc_a, rpc_b;
  logic [1:0]  red_a, red_b;
  logic [31:0] bcnt_a, mcnt_a, bcnt_b, mcnt_b;

  int n_tests;
  int n_fail;

  branch_predictor_btb #(.ENTRIES(64), .CNT_BITS(2), .XLEN(32)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .PCF(pcf),
    .BtbHitF(hit_a), .PredTakenF(pt_a), .PredTargetF(ptgt_a),
    .BranchValidE(valid_e), .PCE(pce), .BranchTakenE(taken_e),
    .BranchTargetE(tgt_e), .PredTakenE(pred_e),
    .RedirectE(red_a), .RedirectPCE(rpc_a),
    .ClearCnt(clr), .BranchCnt(bcnt_a), .MissCnt(mcnt_a)
  );

  branch_predictor_btb #(.ENTRIES(16), .CNT_BITS(1), .XLEN(32)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .PCF(pcf),
    .BtbHitF(hit_b), .PredTakenF(pt_b), .PredTargetF(ptgt_b),
    .BranchValidE(valid_e), .PCE(pce), .BranchTakenE(taken_e),
    .BranchTargetE(tgt_e), .PredTakenE(pred_e),
    .RedirectE(red_b), .RedirectPCE(rpc_b),
    .ClearCnt(clr), .BranchCnt(bcnt_b), .MissCnt(mcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tg, input logic pr);
    valid_e = v; pce = pc; taken_e = tk; tgt_e = tg; pred_e = pr;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    pcf = 32'h100; clr = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    check("rst_hit", {31'b0, hit_a}, 32'd0);
    check("rst_pt", {31'b0, pt_a}, 32'd0);
    check("rst_tgt", ptgt_a, 32'h0);
    check("rst_bcnt", bcnt_a, 32'd0);
    check("rst_mcnt", mcnt_a, 32'd0);
    tick();
    rst_n_a = 1'b1;

    // Loop branch: first taken, mispredicted not-taken.
    ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    #1;
    check("loop_red", {30'b0, red_a}, 32'h1);
    check("loop_rpc", rpc_a, 32'h80);
    check("loop_pre_hit", {31'b0, hit_a}, 32'd0);
    tick();
    ex(1'b0, 32'h100, 1'b1, 32'h80, 1'b0);
    #1;
    check("noval_red", {30'b0, red_a}, 32'h0);
    check("noval_rpc", rpc_a, 32'h0);
    check("loop_hit", {31'b0, hit_a}, 32'd1);
    check("loop_pt", {31'b0, pt_a}, 32'd1);
    check("loop_tgt", ptgt_a, 32'h80);
    check("loop_bcnt", bcnt_a, 32'd1);
    check("loop_mcnt", mcnt_a, 32'd1);

    // Three correctly predicted taken: ctr 10 -> 11 (saturates).
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
      #1;
      check($sformatf("sat_red%0d", i), {30'b0, red_a}, 32'h0);
      tick();
    end
    ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1);
    #1;
    check("nt1_red", {30'b0, red_a}, 32'h3);
    check("nt1_rpc", rpc_a, 32'h104);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("nt1_pt", {31'b0, pt_a}, 32'd1);
    ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("nt2_hit", {31'b0, hit_a}, 32'd1);
    check("nt2_pt", {31'b0, pt_a}, 32'd0);
    check("nt2_bcnt", bcnt_a, 32'd6);
    check("nt2_mcnt", mcnt_a, 32'd3);

    // Aliasing: 0x200 shares index 0 with 0x100.
    ex(1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("alias_old_hit", {31'b0, hit_a}, 32'd0);
    pcf = 32'h200;
    #1;
    check("alias_new_pt", {31'b0, pt_a}, 32'd1);
    check("alias_new_tgt", ptgt_a, 32'h300);
    check("alias_mcnt", mcnt_a, 32'd4);

    // Same-cycle lookup of the entry being allocated sees old contents.
    pcf = 32'h400;
    ex(1'b1, 32'h400, 1'b1, 32'h500, 1'b0);
    #1;
    check("same_pt_now", {31'b0, pt_a}, 32'd0);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("same_pt_next", {31'b0, pt_a}, 32'd1);
    check("same_tgt_next", ptgt_a, 32'h500);
    check("same_bcnt", bcnt_a, 32'd8);

    // Clear beats a simultaneous mispredicted branch.
    clr = 1'b1;
    ex(1'b1, 32'h600, 1'b1, 32'h700, 1'b0);
    tick();
    clr = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("clr_bcnt", bcnt_a, 32'd0);
    check("clr_mcnt", mcnt_a, 32'd0);
    ex(1'b1, 32'h400, 1'b1, 32'h500, 1'b1);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("postclr_bcnt", bcnt_a, 32'd1);
    check("postclr_mcnt", mcnt_a, 32'd0);

    // 1-bit instance.
    rst_n_b = 1'b1;
    pcf = 32'h40;
    ex(1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("b_alloc_hit", {31'b0, hit_b}, 32'd1);
    check("b_alloc_pt", {31'b0, pt_b}, 32'd1);
    check("b_alloc_tgt", ptgt_b, 32'h20);
    ex(1'b1, 32'h40, 1'b0, 32'h20, 1'b1);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("b_nt_hit", {31'b0, hit_b}, 32'd1);
    check("b_nt_pt", {31'b0, pt_b}, 32'd0);
    ex(1'b1, 32'h40, 1'b1, 32'h24, 1'b0);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("b_tk_pt", {31'b0, pt_b}, 32'd1);
    check("b_tk_tgt", ptgt_b, 32'h24);
    check("b_bcnt", bcnt_b, 32'd3);
    check("b_mcnt", mcnt_b, 32'd3);

    // Asynchronous reset mid-cycle: outputs drop without a clock edge.
    #2;
    rst_n_b = 1'b0;
    #1;
    check("b_async_hit", {31'b0, hit_b}, 32'd0);
    check("b_async_tgt", ptgt_b, 32'h0);
    check("b_async_bcnt", bcnt_b, 32'd0);
    ex(1'b1, 32'h40, 1'b1, 32'h88, 1'b0);
    #1;
    check("b_rst_red", {30'b0, red_b}, 32'h1);
    check("b_rst_rpc", rpc_b, 32'h88);
    tick();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("b_rst_noupd", {31'b0, hit_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It combines a direct-mapped branch target buffer with a per-entry N-bit saturating direction counter. The block makes a combinational predict-taken/target decision for the fetch PC (IF) and updates from the resolved branch in EX. In EX it also produces the 2-bit redirect code and redirect PC for the hazard unit, and keeps branch/mispredict performance counters. With CNT_BITS=1 it behaves as a 1-bit BHT.

## Interface
- ENTRIES, 64, BTB/BHT entry count; power of two, ≥2; IDX = log2(ENTRIES)
- CNT_BITS, 2, direction-counter width, 1..4
- XLEN, 32, PC/target width; tag = PC[XLEN-1:IDX+2]
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCF  in  XLEN  fetch-stage PC
- BtbHitF  out  1  entry valid and tag matches PCF
- PredTakenF  out  1  BtbHitF && counter MSB == 1
- PredTargetF  out  XLEN  stored target; 0 when !BtbHitF
- BranchValidE  in  1  conditional branch in EX, already stall/flush-qualified
- PCE  in  XLEN  EX-stage branch PC
- BranchTakenE  in  1  resolved outcome from the comparator
- BranchTargetE  in  XLEN  computed taken target
- PredTakenE  in  1  PredTakenF carried down the pipeline to EX
- RedirectE  out  2  00 none, 01 fetch BranchTargetE, 11 fetch PCE+4; 10 never driven
- RedirectPCE  out  XLEN  redirect address; 0 when RedirectE==00
- ClearCnt  in  1  synchronous clear of performance counters
- BranchCnt  out  32  resolved branches
- MissCnt  out  32  mispredicted branches

## Operation
- Entry fields: valid, tag, target, ctr[CNT_BITS-1:0]. Index = PC[IDX+1:2].
- Constants:
  - WT (weakly taken) = 2^(CNT_BITS-1)
  - WN (weakly not-taken) = WT-1
  - MAX = 2^CNT_BITS-1
- Lookup (combinational): read entry[index(PCF)] and compare tags.
- Redirect (combinational, meaningful only when BranchValidE=1; otherwise 00):
  - BranchTakenE && !PredTakenE → 01, RedirectPCE = BranchTargetE.
  - !BranchTakenE && PredTakenE → 11, RedirectPCE = PCE+4 (mod 2^XLEN).
  - Otherwise → 00.
- Update on a clk edge with BranchValidE=1, entry e = index(PCE), hit = valid && tag match:
  - Hit, taken: ctr = min(ctr+1, MAX); target = BranchTargetE.
  - Hit, not taken: ctr = max(ctr-1, 0). Entry stays valid.
  - Miss, taken: allocate or replace. Set valid=1, tag, target, ctr=WT.
  - Miss, not taken: no change.
  - CNT_BITS=1: WT=1, WN=0, so a single outcome flips the prediction.
- Performance counters:
  - BranchCnt increments on every BranchValidE.
  - MissCnt increments when RedirectE != 00.
  - Both wrap modulo 2^32.
  - ClearCnt has priority: the counters go to 0 that edge and that cycle's event is dropped.
- Reset (async, rst_n low):
  - All valid bits cleared; all ctr = WN; targets/tags = 0; BranchCnt = MissCnt = 0.
  - Therefore BtbHitF = PredTakenF = 0 and PredTargetF = 0 immediately, including mid-operation.
  - RedirectE/RedirectPCE stay combinational from inputs during reset.
  - No update occurs while rst_n is low.
- Storage is flops (ENTRIES small). There is no read-write bypass.

## Timing
- IF lookup: zero latency, combinational from PCF.
- EX redirect: zero latency, combinational from EX inputs.
- Update is written at the clk edge ending the EX cycle. It is visible to PCF from the next cycle.
- Same-cycle PCF index == PCE index: fetch sees pre-update contents.
- Back-to-back updates to one entry on consecutive cycles each apply in order.
- A stalled EX must hold BranchValidE=0 after the first accepted cycle, so each branch is counted once; this is the upstream qualification rule.

## Test plan
- Reset → any PCF gives BtbHitF=0, PredTakenF=0, PredTargetF=0; BranchCnt=MissCnt=0.
- Loop branch (CNT_BITS=2), PCE=0x100, target 0x80, taken, PredTakenE=0:
  - RedirectE=01, RedirectPCE=0x80.
  - Next cycle, PCF=0x100 gives BtbHitF=1, PredTakenF=1, PredTargetF=0x80, ctr=10.
  - BranchCnt=1, MissCnt=1.
- Saturation and hysteresis (CNT_BITS=2), continuing from the loop test:
  - Three more taken with PredTakenE=1 → ctr=11, RedirectE=00 each.
  - One not-taken with PredTakenE=1 → RedirectE=11, RedirectPCE=0x104, ctr=10, still predicts taken.
  - A second not-taken → ctr=01, PredTakenF=0 while BtbHitF=1.
- Aliasing (ENTRIES=64), continuing: taken at PCE=0x200 (same index 0 as 0x100, target 0x300):
  - Afterwards PCF=0x100 gives BtbHitF=0.
  - PCF=0x200 gives PredTakenF=1, PredTargetF=0x300.
- Same-cycle hazard and clear:
  - PCF=PCE=0x400 on the allocating edge → PredTakenF=0 that cycle, 1 the next.
  - ClearCnt=1 with BranchValidE=1 and a mispredict → both counters read 0 after the edge.
- CNT_BITS=1 instance: allocate taken at 0x40, then one not-taken → PredTakenF=0 next cycle. Assert rst_n mid-sequence → BtbHitF drops in the same cycle without waiting for clk.
